// File: rtl/game_pkg.sv
// game_pkg: key code constants, key code type and keypad FSM state enum.
package game_pkg;
  typedef logic [3:0] key_code_t;
  localparam key_code_t KEY_NONE = 4'd0;
  localparam key_code_t KEY_STAR = 4'd10;
  localparam key_code_t KEY_ZERO = 4'd11;
  localparam key_code_t KEY_HASH = 4'd12;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} kp_state_t;
  // Row 3 lands on 10/11/12 naturally, giving '*', '0', '#'.
  function automatic key_code_t key_code(input logic [1:0] row, input logic [1:0] col);
    return key_code_t'({2'b00, row}) * 4'd3 + {2'b00, col} + 4'd1;
  endfunction
endpackage

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: column phase timer; strobes the last clock of each phase
// and of each three-column frame.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] col_o,
  output logic       phase_end_o,
  output logic       frame_end_o
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  assign phase_end_o = cnt_q == CW'(SCAN_DIV - 1);
  assign frame_end_o = phase_end_o && col_q == 2'd2;
  assign cnt_d = phase_end_o ? '0 : cnt_q + 1'b1;
  assign col_d = !phase_end_o ? col_q : col_q == 2'd2 ? 2'd0 : col_q + 2'd1;
  assign col_o = col_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      col_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 3x4 keypad scanner with ghost rejection and debounce.
// Define KEYPAD_SCAN_REPEAT_EN to re-pulse key_valid while a key is held.
module keypad_scan
  import game_pkg::*;
#(
  parameter int SCAN_DIV        = 25000,
  parameter int DEBOUNCE_FRAMES = 8,
  parameter int REPEAT_FRAMES   = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] key_col,
  input  logic [3:0] key_row,
  output logic [3:0] key_data,
  output logic       key_valid
);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  logic [1:0] col;
  logic       phase_end, frame_end;
  logic [3:0] row_s1_q, row_s2_q;
  logic       acc_any_q, acc_multi_q, any_d, multi_d, row_any, row_one;
  key_code_t  acc_code_q, code_d, frame_code, cand_q, key_data_q;
  logic [1:0] row_idx;
  kp_state_t  state_q;
  logic [DW-1:0] deb_q;
  logic       key_valid_q, fresh, press_ok, release_ok;
  int         deb_inc, press_cnt;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .col_o(col), .phase_end_o(phase_end), .frame_end_o(frame_end)
  );

  assign key_col   = 3'b001 << col;
  assign key_data  = key_data_q;
  assign key_valid = key_valid_q;

  // Frame accumulation: a second key anywhere in the frame marks it as ghosted.
  assign row_any    = |row_s2_q;
  assign row_one    = row_any && ((row_s2_q & (row_s2_q - 4'd1)) == 4'd0);
  assign row_idx    = row_s2_q[0] ? 2'd0 : row_s2_q[1] ? 2'd1 : row_s2_q[2] ? 2'd2 : 2'd3;
  assign any_d      = acc_any_q | row_any;
  assign multi_d    = acc_multi_q | (row_any && (!row_one || acc_any_q));
  assign code_d     = row_any ? key_code(row_idx, col) : acc_code_q;
  assign frame_code = (any_d && !multi_d) ? code_d : KEY_NONE;

  assign fresh      = state_q == SCAN || frame_code != cand_q;
  assign deb_inc    = int'(deb_q) + 1;
  assign press_cnt  = fresh ? 1 : deb_inc;
  assign press_ok   = press_cnt >= DEBOUNCE_FRAMES;
  assign release_ok = (state_q == PRESSED ? 1 : deb_inc) >= DEBOUNCE_FRAMES;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_code_q  <= KEY_NONE;
    end else begin
      row_s1_q <= key_row;
      row_s2_q <= row_s1_q;
      if (phase_end) begin
        acc_any_q   <= frame_end ? 1'b0 : any_d;
        acc_multi_q <= frame_end ? 1'b0 : multi_d;
        acc_code_q  <= frame_end ? KEY_NONE : code_d;
      end
    end

`ifdef KEYPAD_SCAN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_FRAMES + 1);
  logic [RW-1:0] rep_q;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_FRAMES;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= SCAN;
      cand_q      <= KEY_NONE;
      deb_q       <= '0;
      key_data_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          SCAN, DEB_PRESS: begin
            if (frame_code == KEY_NONE) begin
              state_q <= SCAN;
            end else begin
              cand_q <= frame_code;
              deb_q  <= DW'(press_ok ? DEBOUNCE_FRAMES : press_cnt);
              if (press_ok) begin
                state_q     <= PRESSED;
                key_data_q  <= frame_code;
                key_valid_q <= 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
                rep_q       <= '0;
`endif
              end else begin
                state_q <= DEB_PRESS;
              end
            end
          end
          PRESSED, DEB_RELEASE: begin
            if (frame_code == KEY_NONE) begin
              deb_q <= DW'(release_ok ? DEBOUNCE_FRAMES : (state_q == PRESSED ? 1 : deb_inc));
              if (release_ok) begin
                state_q    <= SCAN;
                key_data_q <= KEY_NONE;
              end else begin
                state_q <= DEB_RELEASE;
              end
            end else if (state_q == DEB_RELEASE) begin
              state_q <= PRESSED;
`ifdef KEYPAD_SCAN_REPEAT_EN
              rep_q   <= '0;
`endif
            end else begin
`ifdef KEYPAD_SCAN_REPEAT_EN
              rep_q       <= (int'(rep_q) + 1 >= REPEAT_FRAMES) ? '0 : rep_q + 1'b1;
              key_valid_q <= int'(rep_q) + 1 >= REPEAT_FRAMES;
`endif
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed keypad scenarios with a pulse scoreboard
// (SCAN_DIV=4, DEBOUNCE_FRAMES=3, REPEAT_FRAMES=4).
module tb_keypad_scan;
  localparam int SD = 4, DF = 3, RF = 4, FRAME = 3 * SD;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [2:0]  key_col;
  logic [3:0]  key_row, key_data;
  logic        key_valid;
  logic [11:0] held = '0;
  logic [3:0]  exp_q[$];
  int          n_chk = 0, n_fail = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)) dut (
    .clk(clk), .rst_n(rst_n), .key_col(key_col), .key_row(key_row),
    .key_data(key_data), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key connects its row to its driven column.
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++) key_row[r] = |(held[r*3 +: 3] & key_col);
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic qempty(input string tag);
    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL %s: observed %0d pulses still expected, expected 0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wf(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && key_valid === 1'b1) begin
      n_chk++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL pulse_unexpected: observed pulse key_data=%0d expected no pulse", key_data);
      end
      if (exp_q.size() > 0) chk("pulse_data", key_data, exp_q.pop_front());
    end

  initial begin
    #1 rst_n = 1'b0;
    #12;
    chk("rst_col", {1'b0, key_col}, 4'd1);
    chk("rst_data", key_data, 4'd0);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    @(negedge clk) rst_n = 1'b1;
    // Key 5 held ten frames
    held[4] = 1'b1; exp_q.push_back(4'd5);
    wf(2); chk("a_f2_data", key_data, 4'd0);
    chk("a_col_frame_start", {1'b0, key_col}, 4'd1);
    wf(1); chk("a_f3_data", key_data, 4'd5);
    wf(7); held = '0;
    wf(2); chk("a_rel2_data", key_data, 4'd5);
    wf(1); chk("a_rel3_data", key_data, 4'd0);
    qempty("a_pulses");
    // Bounce: two frames only
    held[4] = 1'b1;
    wf(2); chk("b_f2_data", key_data, 4'd0);
    held = '0;
    wf(2); chk("b_after_data", key_data, 4'd0);
    qempty("b_pulses");
    // Ghost: keys 1 and 2, then key 2 released
    held[0] = 1'b1; held[1] = 1'b1;
    wf(4); chk("c_ghost_data", key_data, 4'd0);
    held[1] = 1'b0; exp_q.push_back(4'd1);
    wf(2); chk("c_f2_data", key_data, 4'd0);
    wf(1); chk("c_f3_data", key_data, 4'd1);
    held = '0;
    wf(4); chk("c_rel_data", key_data, 4'd0);
    qempty("c_pulses");
    // '#' held, reset while pressed
    held[11] = 1'b1; exp_q.push_back(4'd12);
    wf(3); chk("d_press_data", key_data, 4'd12);
    wf(1); rst_n = 1'b0; #2;
    chk("d_rst_data", key_data, 4'd0);
    chk("d_rst_valid", {3'b0, key_valid}, 4'd0);
    chk("d_rst_col", {1'b0, key_col}, 4'd1);
    qempty("d_pre_rst_pulses");
    @(negedge clk) rst_n = 1'b1;
    exp_q.push_back(4'd12);
    wf(2); chk("d_f2_data", key_data, 4'd0);
    wf(1); chk("d_f3_data", key_data, 4'd12);
    held = '0;
    wf(4); chk("d_rel_data", key_data, 4'd0);
    qempty("d_pulses");
    // Key 7 with one-frame gap
    held[6] = 1'b1; exp_q.push_back(4'd7);
    wf(4); chk("e_press_data", key_data, 4'd7);
    held = '0;
    wf(1); chk("e_gap_data", key_data, 4'd7);
    held[6] = 1'b1;
    wf(3); chk("e_again_data", key_data, 4'd7);
    held = '0;
    wf(2); chk("e_rel2_data", key_data, 4'd7);
    wf(1); chk("e_rel3_data", key_data, 4'd0);
    qempty("e_pulses");
    // Key 9 held fifteen frames
    held[8] = 1'b1; exp_q.push_back(4'd9);
`ifdef KEYPAD_SCAN_REPEAT_EN
    repeat (3) exp_q.push_back(4'd9);
`endif
    wf(3); chk("f_press_data", key_data, 4'd9);
    wf(12); chk("f_hold_data", key_data, 4'd9);
    held = '0;
    wf(3); chk("f_rel_data", key_data, 4'd0);
    qempty("f_pulses");
    // Key '0' code
    held[10] = 1'b1; exp_q.push_back(4'd11);
    wf(3); chk("g_press_data", key_data, 4'd11);
    held = '0;
    wf(3); chk("g_rel_data", key_data, 4'd0);
    qempty("g_pulses");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 25000, meaning clocks per column phase (minimum 2).
REQ-002 The module SHALL have parameter DEBOUNCE_FRAMES, default 8, meaning consecutive identical scan frames needed to accept a press or a release (minimum 1).
REQ-003 The module SHALL have parameter REPEAT_FRAMES, default 200, meaning frames between auto-repeat pulses, used only when auto-repeat is compiled in.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 key_col  output  3  one-hot active-high column drive for the 3x4 keypad; bit 0 is the left column.
REQ-008 key_row  input  4  active-high row sense; bit 0 is the top row; input is asynchronous to clk.
REQ-009 key_data  output  4  debounced key code: 1-9 for digits, 10 for '*', 11 for '0', 12 for '#', 0 for no key.
REQ-010 key_valid  output  1  single-cycle pulse marking an accepted press; it is the strobe gameState consumes.

Function
REQ-011 key_row SHALL pass through a 2-flop synchroniser before any use.
REQ-012 Each column phase SHALL last SCAN_DIV clocks; column order 0,1,2, then wrap to 0; three phases form one frame.
REQ-013 Rows SHALL be sampled on the last clock of each phase; code = row*3 + col + 1, where row 3 maps to 10/11/12.
REQ-014 Frame result: no row bit set gives 0; exactly one key gives its code; two or more keys gives 0 (ghost rejection).
REQ-015 FSM states: SCAN, DEB_PRESS, PRESSED, DEB_RELEASE; reset state SCAN.
REQ-016 SCAN: a nonzero frame result SHALL latch the candidate code, set the debounce count to 1 and go to DEB_PRESS; a zero result stays in SCAN.
REQ-017 DEB_PRESS: a frame equal to the candidate SHALL increment the count; a different nonzero frame SHALL replace the candidate and reset the count to 1; a zero frame returns to SCAN.
REQ-018 When the count reaches DEBOUNCE_FRAMES, the FSM SHALL enter PRESSED, drive key_data = candidate and pulse key_valid for exactly 1 clk in the same cycle.
REQ-019 PRESSED: key_data SHALL hold; a zero frame goes to DEB_RELEASE with count 1; a different nonzero key is ignored, with no new pulse until a release is accepted.
REQ-020 DEB_RELEASE: DEBOUNCE_FRAMES consecutive zero frames SHALL return to SCAN and set key_data to 0; any nonzero frame returns to PRESSED with no pulse.
REQ-021 key_data SHALL be 0 in SCAN and DEB_PRESS, and key_valid SHALL be 0 except as in REQ-018 and REQ-030.
REQ-022 Press latency SHALL be DEBOUNCE_FRAMES frames, measured from the first frame boundary whose sample sees the key, +0 clk.
REQ-023 Phase and frame counters SHALL wrap silently, and the debounce count SHALL saturate at DEBOUNCE_FRAMES.

Reset
REQ-024 While rst_n=0: key_col=3'b001, key_data=0, key_valid=0, FSM in SCAN, and all counters and synchronisers cleared.
REQ-025 Asserting reset mid-debounce or while PRESSED SHALL discard the key, with no pulse on release of reset.
REQ-026 After rst_n deasserts, scanning SHALL restart at column 0, phase count 0.

Configuration
REQ-027 Macro KEYPAD_SCAN_REPEAT_EN SHALL control auto-repeat.
REQ-028 With KEYPAD_SCAN_REPEAT_EN defined: while in PRESSED, key_valid SHALL re-pulse every REPEAT_FRAMES frames with key_data unchanged, and the repeat counter SHALL clear on entry to PRESSED.
REQ-029 Without KEYPAD_SCAN_REPEAT_EN: exactly one pulse per accepted press, and no repeat counter logic is generated.
REQ-030 REQ-028 is the only other source of key_valid pulses.

Structure
REQ-031 Shared package game_pkg SHALL hold the KEY_NONE(0), KEY_STAR(10), KEY_ZERO(11) and KEY_HASH(12) constants, the 4-bit key code type, and the FSM state enum.
REQ-032 One sub-module, keypad_tick_gen, SHALL generate the phase-end strobe and the column index from SCAN_DIV; the FSM and debounce logic SHALL stay in keypad_scan.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 clk)
REQ-033 Hold key 5 (row1,col1) for 10 frames -> exactly one key_valid pulse; key_data=5 from the 3rd frame boundary until 3 zero frames after release.
REQ-034 Key 5 pressed for 2 frames only (bounce) -> no key_valid pulse and key_data stays 0.
REQ-035 Keys 1 and 2 held together -> no pulse; after releasing key 2, key 1 gives one pulse with key_data=1.
REQ-036 rst_n pulsed low while in PRESSED with '#' held -> key_data=0 immediately; after reset, re-debounce gives one pulse with key_data=12.
REQ-037 Key 7 held, 1 zero frame, then held again -> one pulse total; key_data remains 7 throughout.
REQ-038 With KEYPAD_SCAN_REPEAT_EN and REPEAT_FRAMES=4, hold key 9 for 15 frames -> pulses at the accept frame and then every 4 frames; without the macro -> one pulse.
